// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue.
// Issues in-order word fetches to a variable-latency instruction memory and
// buffers the returned words, together with their PC, in a small FIFO that
// feeds decode through a valid/ready handshake. A redirect from execute
// flushes the FIFO, restarts fetching at the target and discards every
// response that was still in flight when the redirect happened.

module instr_prefetch_queue_chk #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 3,
    parameter int unsigned OUT_W = 2
) (
    input logic             clk,
    input logic             rst,
    input logic             push,
    input logic             pop,
    input logic [CNT_W-1:0] count,
    input logic [OUT_W-1:0] out_cnt,
    input logic [OUT_W-1:0] drop_cnt,
    input logic             rsp_valid
);
    // The credit rule must never let a response land in a full queue.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(push && !pop && (count == CNT_W'(DEPTH))));

    // A response can only answer a request that is still in flight.
    a_rsp_expected: assert property (@(posedge clk) disable iff (!rst)
        !(rsp_valid && (out_cnt == {OUT_W{1'b0}})));

    // Stale responses are a subset of the in-flight requests.
    a_drop_bounded: assert property (@(posedge clk) disable iff (!rst)
        (drop_cnt <= out_cnt));
endmodule

module instr_prefetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned MAX_OUT  = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      redirect_i,
    input  logic [31:0]               redirect_pc_i,
    output logic                      imem_req_valid,
    input  logic                      imem_req_ready,
    output logic [31:0]               imem_req_addr,
    input  logic                      imem_rsp_valid,
    input  logic [31:0]               imem_rsp_data,
    output logic                      instr_valid,
    input  logic                      instr_ready,
    output logic [31:0]               instrD,
    output logic [31:0]               PCD,
    output logic [31:0]               PCplus4D,
    output logic [$clog2(DEPTH):0]    occupancy
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned OUT_W = $clog2(MAX_OUT + 1);

    // RUN: every response is kept. DRAIN: responses to pre-redirect requests are discarded.
    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    // Sequential word address; wraps naturally at 2^32.
    function automatic logic [31:0] next_word_pc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

    state_t           state_r;
    state_t           state_next_s;
    logic [31:0]      fetch_pc_r;
    logic [31:0]      rsp_pc_r;
    logic [OUT_W-1:0] out_cnt_r;
    logic [OUT_W-1:0] out_cnt_next_s;
    logic [OUT_W-1:0] drop_cnt_r;
    logic [OUT_W-1:0] drop_cnt_next_s;
    logic [CNT_W-1:0] count_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [31:0]      mem_pc_r   [DEPTH];
    logic [31:0]      mem_data_r [DEPTH];
    logic [31:0]      credit_sum_s;
    logic             req_valid_s;
    logic             issue_s;
    logic             rsp_keep_s;
    logic             rsp_drop_s;
    logic             head_valid_s;
    logic             push_s;
    logic             pop_s;

    // Request credit check and qualification of all handshakes this cycle.
    always_comb begin
        credit_sum_s = 32'(count_r) + 32'(out_cnt_r);
        req_valid_s  = 1'b0;
        // Every in-flight request owns a queue slot, so a response always finds room.
        if (rst && !redirect_i && (out_cnt_r < OUT_W'(MAX_OUT)) && (credit_sum_s < DEPTH)) begin
            req_valid_s = 1'b1;
        end else begin
            req_valid_s = 1'b0;
        end
        issue_s      = req_valid_s && imem_req_ready;
        rsp_drop_s   = imem_rsp_valid && (state_r == ST_DRAIN);
        rsp_keep_s   = imem_rsp_valid && (state_r == ST_RUN);
        head_valid_s = (count_r != {CNT_W{1'b0}});
        // A redirect cancels any same-cycle push or pop.
        push_s       = rsp_keep_s && !redirect_i;
        pop_s        = head_valid_s && instr_ready && !redirect_i;
    end

    // Next values of the in-flight and stale-response counters.
    always_comb begin
        out_cnt_next_s  = out_cnt_r;
        drop_cnt_next_s = drop_cnt_r;
        if (issue_s && !imem_rsp_valid) begin
            out_cnt_next_s = out_cnt_r + OUT_W'(1);
        end else if (!issue_s && imem_rsp_valid) begin
            out_cnt_next_s = out_cnt_r - OUT_W'(1);
        end else begin
            out_cnt_next_s = out_cnt_r;
        end
        // On redirect every request still in flight (old stale ones included) becomes stale.
        if (redirect_i) begin
            drop_cnt_next_s = out_cnt_next_s;
        end else if (rsp_drop_s) begin
            drop_cnt_next_s = drop_cnt_r - OUT_W'(1);
        end else begin
            drop_cnt_next_s = drop_cnt_r;
        end
    end

    // RUN/DRAIN next-state decision, driven by the stale-response count.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (drop_cnt_next_s != {OUT_W{1'b0}}) begin
                    state_next_s = ST_DRAIN;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (drop_cnt_next_s == {OUT_W{1'b0}}) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_DRAIN;
                end
            end
            default: begin
                state_next_s = ST_RUN;
            end
        endcase
    end

    // FSM state and request/response bookkeeping registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= ST_RUN;
            out_cnt_r  <= {OUT_W{1'b0}};
            drop_cnt_r <= {OUT_W{1'b0}};
        end else begin
            state_r    <= state_next_s;
            out_cnt_r  <= out_cnt_next_s;
            drop_cnt_r <= drop_cnt_next_s;
        end
    end

    // Fetch address and the PC tagged onto the next kept response.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_r <= RESET_PC;
            rsp_pc_r   <= RESET_PC;
        end else if (redirect_i) begin
            fetch_pc_r <= redirect_pc_i;
            rsp_pc_r   <= redirect_pc_i;
        end else begin
            if (issue_s) begin
                fetch_pc_r <= next_word_pc(fetch_pc_r);
            end
            if (push_s) begin
                rsp_pc_r <= next_word_pc(rsp_pc_r);
            end
        end
    end

    // Queue storage, pointers and fill level; a redirect empties the queue.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_r  <= {CNT_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_pc_r[i]   <= 32'h0000_0000;
                mem_data_r[i] <= 32'h0000_0000;
            end
        end else if (redirect_i) begin
            count_r  <= {CNT_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
        end else begin
            if (push_s) begin
                mem_pc_r[wr_ptr_r]   <= rsp_pc_r;
                mem_data_r[wr_ptr_r] <= imem_rsp_data;
                wr_ptr_r             <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            if (push_s && !pop_s) begin
                count_r <= count_r + CNT_W'(1);
            end else if (pop_s && !push_s) begin
                count_r <= count_r - CNT_W'(1);
            end
        end
    end

    // Head entry toward decode; held at zero while the queue is empty.
    always_comb begin
        instrD   = 32'h0000_0000;
        PCD      = 32'h0000_0000;
        PCplus4D = 32'h0000_0000;
        if (head_valid_s) begin
            instrD   = mem_data_r[rd_ptr_r];
            PCD      = mem_pc_r[rd_ptr_r];
            PCplus4D = next_word_pc(mem_pc_r[rd_ptr_r]);
        end else begin
            instrD   = 32'h0000_0000;
            PCD      = 32'h0000_0000;
            PCplus4D = 32'h0000_0000;
        end
    end

    assign imem_req_valid = req_valid_s;
    assign imem_req_addr  = fetch_pc_r;
    assign instr_valid    = head_valid_s;
    assign occupancy      = count_r;

    instr_prefetch_queue_chk #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W),
        .OUT_W (OUT_W)
    ) u_chk (
        .clk       (clk),
        .rst       (rst),
        .push      (push_s),
        .pop       (pop_s),
        .count     (count_r),
        .out_cnt   (out_cnt_r),
        .drop_cnt  (drop_cnt_r),
        .rsp_valid (imem_rsp_valid)
    );
endmodule
